// File: rtl/tpu_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_instr_sequencer
//
// Instruction front end for the TPU top level. The host pushes 80-bit
// instructions into an internal FIFO and then pulses start_in. The sequencer
// fetches each word, decodes it, issues single-cycle control pulses and
// updates the held read/config fields, then honours the per-instruction wait
// count. A HALT or an illegal opcode ends the run with a done_out pulse. An
// illegal opcode also sets the sticky err_out flag.
//
// Instruction layout:
//   [79:76] opcode     [75:67] ptr_select  [66] transpose   [65:50] addr
//   [49:34] row_size   [33:18] col_size    [17:14] pathway  [13:12] sys_mode
//   [11:0]  wait
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   instr_in/_valid_in       host write port; instr_ready_out = FIFO not full
//   start_in                 run pulse, honoured only while idle
//   abort_in                 synchronous abort: back to idle and flush the FIFO
//   ub_rd_start_out          one-cycle UB read start pulse
//   ub_rd_*_out, ub_ptr_*    held UB read fields (loaded by UB_READ)
//   sys_switch_out           one-cycle weight switch pulse
//   vpu_data_pathway_out,
//   sys_mode_out             held datapath config (loaded by SET_CFG)
//   busy_out                 sequencer not idle
//   done_out                 one-cycle pulse on HALT or on an illegal opcode
//   err_out                  sticky illegal-opcode flag, cleared by start
//   fifo_count_out           FIFO occupancy
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module tpu_instr_sequencer #(
  parameter int unsigned INSTR_DEPTH = 16,
  parameter int unsigned INSTR_WIDTH = 80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTR_WIDTH-1:0]       instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic                         start_in,
  input  logic                         abort_in,
  output logic                         ub_rd_start_out,
  output logic                         ub_rd_transpose_out,
  output logic [8:0]                   ub_ptr_select_out,
  output logic [15:0]                  ub_rd_addr_out,
  output logic [15:0]                  ub_rd_row_size_out,
  output logic [15:0]                  ub_rd_col_size_out,
  output logic                         sys_switch_out,
  output logic [3:0]                   vpu_data_pathway_out,
  output logic [1:0]                   sys_mode_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         err_out,
  output logic [$clog2(INSTR_DEPTH):0] fifo_count_out
);

  localparam int unsigned PtrW = $clog2(INSTR_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [3:0] OpNop    = 4'd0;
  localparam logic [3:0] OpUbRead = 4'd1;
  localparam logic [3:0] OpSwitch = 4'd2;
  localparam logic [3:0] OpSetCfg = 4'd3;
  localparam logic [3:0] OpWait   = 4'd4;
  localparam logic [3:0] OpHalt   = 4'd5;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StWait} state_e;

  state_e state_q, state_d;

  // FIFO storage and bookkeeping
  logic [INSTR_WIDTH-1:0] mem_q [INSTR_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ready_q, ready_d;
  logic                   push, pop;

  // Decoded head-of-FIFO fields
  logic [INSTR_WIDTH-1:0] head;
  logic [3:0]             head_op;
  logic [8:0]             head_ptr;
  logic                   head_transpose;
  logic [15:0]            head_addr;
  logic [15:0]            head_row;
  logic [15:0]            head_col;
  logic [3:0]             head_pathway;
  logic [1:0]             head_mode;
  logic [11:0]            head_wait;

  // Instruction register: only the parts EXEC still needs after the pop
  logic [3:0]  op_q, op_d;
  logic [11:0] wait_q, wait_d;
  logic [11:0] wait_cnt_q, wait_cnt_d;

  // Output registers
  logic        rd_start_q, rd_start_d;
  logic        rd_transpose_q, rd_transpose_d;
  logic [8:0]  ptr_select_q, ptr_select_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [15:0] rd_row_q, rd_row_d;
  logic [15:0] rd_col_q, rd_col_d;
  logic        switch_q, switch_d;
  logic [3:0]  pathway_q, pathway_d;
  logic [1:0]  mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  assign head           = mem_q[rd_ptr_q];
  assign head_op        = head[79:76];
  assign head_ptr       = head[75:67];
  assign head_transpose = head[66];
  assign head_addr      = head[65:50];
  assign head_row       = head[49:34];
  assign head_col       = head[33:18];
  assign head_pathway   = head[17:14];
  assign head_mode      = head[13:12];
  assign head_wait      = head[11:0];

  // Sequencer next-state and output decode. Opcode effects are decoded from
  // the FIFO head during FETCH so the registered pulses and held fields are
  // visible in the EXEC cycle.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wait_d         = wait_q;
    wait_cnt_d     = wait_cnt_q;
    pop            = 1'b0;
    rd_start_d     = 1'b0;
    switch_d       = 1'b0;
    done_d         = 1'b0;
    err_d          = err_q;
    rd_transpose_d = rd_transpose_q;
    ptr_select_d   = ptr_select_q;
    rd_addr_d      = rd_addr_q;
    rd_row_d       = rd_row_q;
    rd_col_d       = rd_col_q;
    pathway_d      = pathway_q;
    mode_d         = mode_q;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StFetch;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        // Uses the registered count, so a word pushed this cycle into an
        // empty FIFO is popped on the next cycle instead.
        if (count_q != '0) begin
          pop     = 1'b1;
          op_d    = head_op;
          wait_d  = head_wait;
          state_d = StExec;
          unique case (head_op)
            OpUbRead: begin
              rd_start_d     = 1'b1;
              rd_transpose_d = head_transpose;
              ptr_select_d   = head_ptr;
              rd_addr_d      = head_addr;
              rd_row_d       = head_row;
              rd_col_d       = head_col;
            end
            OpSwitch: switch_d = 1'b1;
            OpSetCfg: begin
              pathway_d = head_pathway;
              mode_d    = head_mode;
            end
            OpNop, OpWait: begin
            end
            OpHalt: done_d = 1'b1;
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      StExec: begin
        if (op_q >= OpHalt) begin
          state_d = StIdle;
        end else if (wait_q == '0) begin
          state_d = StFetch;
        end else begin
          wait_cnt_d = wait_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 12'd1;
        if (wait_cnt_q == 12'd1) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything: no pop, no pulses, held fields untouched.
    if (abort_in) begin
      state_d        = StIdle;
      pop            = 1'b0;
      rd_start_d     = 1'b0;
      switch_d       = 1'b0;
      done_d         = 1'b0;
      err_d          = err_q;
      op_d           = op_q;
      wait_d         = wait_q;
      rd_transpose_d = rd_transpose_q;
      ptr_select_d   = ptr_select_q;
      rd_addr_d      = rd_addr_q;
      rd_row_d       = rd_row_q;
      rd_col_d       = rd_col_q;
      pathway_d      = pathway_q;
      mode_d         = mode_q;
    end

    busy_d = (state_d != StIdle);
  end

  // FIFO pointer and occupancy update. A push in the abort cycle is dropped
  // along with the rest of the flushed contents.
  always_comb begin
    push     = instr_valid_in && ready_q && !abort_in;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
    ready_d = (count_d != CntW'(INSTR_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ready_q        <= 1'b1;
      op_q           <= '0;
      wait_q         <= '0;
      wait_cnt_q     <= '0;
      rd_start_q     <= 1'b0;
      rd_transpose_q <= 1'b0;
      ptr_select_q   <= '0;
      rd_addr_q      <= '0;
      rd_row_q       <= '0;
      rd_col_q       <= '0;
      switch_q       <= 1'b0;
      pathway_q      <= '0;
      mode_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ready_q        <= ready_d;
      op_q           <= op_d;
      wait_q         <= wait_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_start_q     <= rd_start_d;
      rd_transpose_q <= rd_transpose_d;
      ptr_select_q   <= ptr_select_d;
      rd_addr_q      <= rd_addr_d;
      rd_row_q       <= rd_row_d;
      rd_col_q       <= rd_col_d;
      switch_q       <= switch_d;
      pathway_q      <= pathway_d;
      mode_q         <= mode_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign instr_ready_out      = ready_q;
  assign fifo_count_out       = count_q;
  assign ub_rd_start_out      = rd_start_q;
  assign ub_rd_transpose_out  = rd_transpose_q;
  assign ub_ptr_select_out    = ptr_select_q;
  assign ub_rd_addr_out       = rd_addr_q;
  assign ub_rd_row_size_out   = rd_row_q;
  assign ub_rd_col_size_out   = rd_col_q;
  assign sys_switch_out       = switch_q;
  assign vpu_data_pathway_out = pathway_q;
  assign sys_mode_out         = mode_q;
  assign busy_out             = busy_q;
  assign done_out             = done_q;
  assign err_out              = err_q;

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for tpu_instr_sequencer. A queue-based model tracks the FIFO and the
// run as "an instruction occupies 2 + wait cycles"; a compare process checks
// every output against it on each falling edge. Directed sequences add literal
// expectations for timing, error handling, abort and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_tpu_instr_sequencer;

  localparam int DEPTH = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_UB   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_CFG  = 4'd3;
  localparam logic [3:0] OP_WAIT = 4'd4;
  localparam logic [3:0] OP_HALT = 4'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        instr_ready_out;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic        ub_rd_start_out;
  logic        ub_rd_transpose_out;
  logic [8:0]  ub_ptr_select_out;
  logic [15:0] ub_rd_addr_out;
  logic [15:0] ub_rd_row_size_out;
  logic [15:0] ub_rd_col_size_out;
  logic        sys_switch_out;
  logic [3:0]  vpu_data_pathway_out;
  logic [1:0]  sys_mode_out;
  logic        busy_out;
  logic        done_out;
  logic        err_out;
  logic [4:0]  fifo_count_out;

  tpu_instr_sequencer #(
    .INSTR_DEPTH(16),
    .INSTR_WIDTH(80)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instr_in             (instr_in),
    .instr_valid_in       (instr_valid_in),
    .instr_ready_out      (instr_ready_out),
    .start_in             (start_in),
    .abort_in             (abort_in),
    .ub_rd_start_out      (ub_rd_start_out),
    .ub_rd_transpose_out  (ub_rd_transpose_out),
    .ub_ptr_select_out    (ub_ptr_select_out),
    .ub_rd_addr_out       (ub_rd_addr_out),
    .ub_rd_row_size_out   (ub_rd_row_size_out),
    .ub_rd_col_size_out   (ub_rd_col_size_out),
    .sys_switch_out       (sys_switch_out),
    .vpu_data_pathway_out (vpu_data_pathway_out),
    .sys_mode_out         (sys_mode_out),
    .busy_out             (busy_out),
    .done_out             (done_out),
    .err_out              (err_out),
    .fifo_count_out       (fifo_count_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [79:0] mq[$];
  bit          m_run, m_term, m_pushed;
  int          m_cd;  // cycles left before the next fetch opportunity
  logic        e_rd, e_tr, e_sw, e_busy, e_done, e_err, e_rdy;
  logic [8:0]  e_ptr;
  logic [15:0] e_addr, e_row, e_col;
  logic [3:0]  e_pw;
  logic [1:0]  e_md;
  int          e_cnt;

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_term = 0; m_pushed = 0; m_cd = 0;
    e_rd = 0; e_tr = 0; e_sw = 0; e_busy = 0; e_done = 0; e_err = 0; e_rdy = 1;
    e_ptr = '0; e_addr = '0; e_row = '0; e_col = '0; e_pw = '0; e_md = '0; e_cnt = 0;
  endtask

  // One clock edge with the given inputs applied.
  task automatic model_step(input bit s, input bit a, input bit v, input logic [79:0] w);
    bit          push_ok;
    logic [79:0] h;
    logic [3:0]  op;
    push_ok = v && (mq.size() < DEPTH);
    e_rd = 0; e_sw = 0; e_done = 0;
    m_pushed = 0;
    if (a) begin
      mq.delete();
      m_run = 0; m_term = 0; m_cd = 0;
    end else begin
      if (!m_run) begin
        if (s) begin
          m_run = 1; m_cd = 0; m_term = 0; e_err = 0;
        end
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0 && m_term) m_run = 0;
      end else if (mq.size() > 0) begin
        h  = mq.pop_front();
        op = h[79:76];
        if (op == OP_UB) begin
          e_rd = 1; e_ptr = h[75:67]; e_tr = h[66];
          e_addr = h[65:50]; e_row = h[49:34]; e_col = h[33:18];
        end else if (op == OP_SW) begin
          e_sw = 1;
        end else if (op == OP_CFG) begin
          e_pw = h[17:14]; e_md = h[13:12];
        end else if (op == OP_HALT) begin
          e_done = 1; m_term = 1;
        end else if (op > OP_HALT) begin
          e_done = 1; e_err = 1; m_term = 1;
        end
        m_cd = m_term ? 1 : 1 + int'(h[11:0]);
      end
      if (push_ok) begin
        mq.push_back(w);
        m_pushed = 1;
      end
    end
    e_busy = m_run;
    e_cnt  = mq.size();
    e_rdy  = (mq.size() < DEPTH);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", instr_ready_out, e_rdy);
      chk("count", fifo_count_out, e_cnt);
      chk("rd_start", ub_rd_start_out, e_rd);
      chk("transpose", ub_rd_transpose_out, e_tr);
      chk("ptr_select", ub_ptr_select_out, e_ptr);
      chk("rd_addr", ub_rd_addr_out, e_addr);
      chk("row_size", ub_rd_row_size_out, e_row);
      chk("col_size", ub_rd_col_size_out, e_col);
      chk("switch", sys_switch_out, e_sw);
      chk("pathway", vpu_data_pathway_out, e_pw);
      chk("sys_mode", sys_mode_out, e_md);
      chk("busy", busy_out, e_busy);
      chk("done", done_out, e_done);
      chk("err", err_out, e_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int n_rd, n_sw, n_done, rd_cyc, sw_cyc, done_cyc, start_cyc;

  function automatic logic [79:0] mk(input logic [3:0] op, input logic [8:0] ptr,
                                     input logic tr, input logic [15:0] addr,
                                     input logic [15:0] row, input logic [15:0] col,
                                     input logic [3:0] pw, input logic [1:0] md,
                                     input logic [11:0] w);
    return {op, ptr, tr, addr, row, col, pw, md, w};
  endfunction

  function automatic logic [79:0] simple(input logic [3:0] op, input logic [11:0] w);
    return mk(op, 9'd0, 1'b0, 16'd0, 16'd0, 16'd0, 4'd0, 2'd0, w);
  endfunction

  function automatic logic [79:0] rnd_instr();
    int         r;
    logic [3:0] op;
    r = $urandom_range(0, 19);
    if (r < 3)       op = OP_NOP;
    else if (r < 7)  op = OP_UB;
    else if (r < 10) op = OP_SW;
    else if (r < 13) op = OP_CFG;
    else if (r < 15) op = OP_WAIT;
    else if (r < 19) op = OP_HALT;
    else             op = 4'($urandom_range(6, 15));
    return mk(op, 9'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 4'($urandom), 2'($urandom), 12'($urandom_range(0, 5)));
  endfunction

  // Called right after a falling edge; returns right after the next one.
  task automatic step(input bit s, input bit a, input bit v, input logic [79:0] w);
    start_in = s; abort_in = a; instr_valid_in = v; instr_in = w;
    @(posedge clk);
    model_step(s, a, v, w);
    cyc++;
    @(negedge clk);
    start_in = 0; abort_in = 0; instr_valid_in = 0;
    if (ub_rd_start_out) begin n_rd++; rd_cyc = cyc; end
    if (sys_switch_out)  begin n_sw++; sw_cyc = cyc; end
    if (done_out)        begin n_done++; done_cyc = cyc; end
  endtask

  task automatic clr_stats();
    n_rd = 0; n_sw = 0; n_done = 0; rd_cyc = -1; sw_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_run();
    start_cyc = cyc;
    step(1, 0, 0, '0);
  endtask

  task automatic run_idle(input int max, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      step(0, 0, 0, '0);
      if (!busy_out) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_ready"}, instr_ready_out, 1);
    chk({p, "_count"}, fifo_count_out, 0);
    chk({p, "_busy"}, busy_out, 0);
    chk({p, "_done"}, done_out, 0);
    chk({p, "_err"}, err_out, 0);
    chk({p, "_rd_start"}, ub_rd_start_out, 0);
    chk({p, "_switch"}, sys_switch_out, 0);
    chk({p, "_fields"}, {ub_rd_transpose_out, ub_ptr_select_out, ub_rd_addr_out}, 0);
    chk({p, "_sizes"}, {ub_rd_row_size_out, ub_rd_col_size_out}, 0);
    chk({p, "_cfg"}, {vpu_data_pathway_out, sys_mode_out}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int pushed;
    model_reset();
    clr_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: UB_READ then HALT
    step(0, 0, 1, mk(OP_UB, 9'd3, 1'b0, 16'h0040, 16'd4, 16'd2, 4'd0, 2'd0, 12'd0));
    step(0, 0, 1, simple(OP_HALT, 12'd0));
    clr_stats();
    start_run();
    run_idle(20, "t1_idle");
    chk("t1_rd_pulses", n_rd, 1);
    chk("t1_first_exec", rd_cyc - start_cyc, 2);
    chk("t1_done_gap", done_cyc - rd_cyc, 2);
    chk("t1_fields", {ub_ptr_select_out, ub_rd_addr_out}, {9'd3, 16'h0040});
    chk("t1_sizes", {ub_rd_row_size_out, ub_rd_col_size_out}, {16'd4, 16'd2});

    // 2: SET_CFG, SWITCH wait=3, HALT
    step(0, 0, 1, mk(OP_CFG, 9'd0, 1'b0, 16'd0, 16'd0, 16'd0, 4'b1011, 2'd2, 12'd0));
    step(0, 0, 1, simple(OP_SW, 12'd3));
    step(0, 0, 1, simple(OP_HALT, 12'd0));
    clr_stats();
    start_run();
    step(0, 0, 0, '0);
    chk("t2_cfg_at_exec", {vpu_data_pathway_out, sys_mode_out}, {4'b1011, 2'd2});
    run_idle(30, "t2_idle");
    chk("t2_sw_pulses", n_sw, 1);
    chk("t2_halt_gap", done_cyc - sw_cyc, 5);
    chk("t2_fields_kept", ub_rd_addr_out, 16'h0040);

    // 3: illegal opcode, then a clean run clears err
    step(0, 0, 1, simple(4'd9, 12'd0));
    clr_stats();
    start_run();
    run_idle(20, "t3_idle");
    chk("t3_err", err_out, 1);
    chk("t3_done", n_done, 1);
    chk("t3_no_pulses", n_rd + n_sw, 0);
    step(0, 0, 1, simple(OP_HALT, 12'd0));
    start_run();
    chk("t3_err_cleared", err_out, 0);
    run_idle(20, "t3b_idle");

    // 4: fill, then drain with overlapping pushes and a late HALT
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, simple(OP_NOP, 12'd0));
    chk("t4_full_ready", instr_ready_out, 0);
    chk("t4_full_count", fifo_count_out, 16);
    clr_stats();
    start_run();
    pushed = 0;
    for (int i = 0; i < 300 && pushed < 7; i++) begin
      step(0, 0, 1, simple((pushed < 6) ? OP_NOP : OP_HALT, 12'd0));
      if (m_pushed) pushed++;
    end
    chk("t4_pushes", pushed, 7);
    run_idle(100, "t4_idle");
    chk("t4_drained", fifo_count_out, 0);
    chk("t4_done", n_done, 1);

    // 5: stall on empty FIFO, then abort during a long wait
    clr_stats();
    start_run();
    repeat (4) step(0, 0, 0, '0);
    chk("t5_stall_busy", busy_out, 1);
    chk("t5_stall_count", fifo_count_out, 0);
    step(0, 0, 1, simple(OP_HALT, 12'd0));
    run_idle(10, "t5_halt_idle");
    chk("t5_halt_done", n_done, 1);
    step(0, 0, 1, simple(OP_WAIT, 12'd100));
    for (int i = 0; i < 5; i++) step(0, 0, 1, simple(OP_NOP, 12'd0));
    clr_stats();
    start_run();
    repeat (6) step(0, 0, 0, '0);
    chk("t5_in_wait", busy_out, 1);
    step(0, 1, 1, simple(OP_NOP, 12'd0));
    chk("t5_abort_busy", busy_out, 0);
    chk("t5_abort_count", fifo_count_out, 0);
    chk("t5_abort_done", n_done, 0);
    chk("t5_held_cfg", {vpu_data_pathway_out, sys_mode_out}, {4'b1011, 2'd2});

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0), rnd_instr());
    end

    // 6: asynchronous reset in the middle of a wait
    step(0, 1, 0, '0);
    step(0, 0, 1, mk(OP_UB, 9'h1ff, 1'b1, 16'hbeef, 16'd7, 16'd9, 4'd0, 2'd0, 12'd0));
    step(0, 0, 1, simple(OP_NOP, 12'd50));
    step(0, 0, 1, simple(OP_HALT, 12'd0));
    start_run();
    repeat (6) step(0, 0, 0, '0);
    chk("t6_busy_before", busy_out, 1);
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals("t6_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    repeat (3) step(0, 0, 0, '0);
    chk("t6_after_count", fifo_count_out, 0);
    chk("t6_after_busy", busy_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
